// File: rtl/wam_inp.sv
// Whack-a-mole input side: synchronises and debounces the tap switches and the
// left/right buttons, judges taps against the lit holes, and keeps score and hardness.
module wam_inp #(
   parameter int unsigned DB_N = 3
) (
   input  logic        clk_19,
   input  logic        rst,
   input  logic [7:0]  sw,
   input  logic        btn_l,
   input  logic        btn_r,
   input  logic [7:0]  holes,
   input  logic        run,
   output logic [7:0]  tap,
   output logic        lft,
   output logic        rgt,
   output logic [7:0]  hit_clr,
   output logic [11:0] score,
   output logic [3:0]  hrdn
);

   localparam int unsigned CW = (DB_N > 1) ? $clog2(DB_N) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_N - 1);

   // Filter lanes: [7:0] switches, [8] left button, [9] right button.
   logic [9:0]    raw;
   logic [9:0]    s1_q, s2_q, d_q, acc;
   logic [CW-1:0] cnt_q [10];

   logic [7:0]  tap_q, hit_clr_q, hit_clr_d, hits, miss;
   logic        lft_q, rgt_q;
   logic [11:0] score_q, score_d;
   logic [3:0]  hrdn_q, hrdn_d;

   assign raw = {btn_r, btn_l, sw};

   always_comb begin
      acc = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         acc[i] = (s2_q[i] != d_q[i]) && (cnt_q[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk_19) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         d_q   <= '0;
         tap_q <= '0;
         lft_q <= 1'b0;
         rgt_q <= 1'b0;
         for (int unsigned i = 0; i < 10; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         for (int unsigned i = 0; i < 10; i++) begin
            if (s2_q[i] != d_q[i]) begin
               if (acc[i]) begin
                  d_q[i]   <= s2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
         tap_q <= acc[7:0];
         // Buttons only report the press, not the release.
         lft_q <= acc[8] & s2_q[8];
         rgt_q <= acc[9] & s2_q[9];
      end
   end

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h999) begin
         if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
         end else begin
            r[3:0] = '0;
            if (v[7:4] != 4'd9) begin
               r[7:4] = v[7:4] + 4'd1;
            end else begin
               r[7:4]  = '0;
               r[11:8] = v[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h000) begin
         if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
         end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
               r[7:4] = v[7:4] - 4'd1;
            end else begin
               r[7:4]  = 4'd9;
               r[11:8] = v[11:8] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      hits      = tap_q & holes;
      miss      = tap_q & ~holes;
      hit_clr_d = hits;
      score_d   = score_q;
      hrdn_d    = hrdn_q;
      // A hit outranks a miss in the same cycle; run gates only the score.
      if (run && (hits != '0)) begin
         score_d = bcd_inc(score_q);
      end else if (run && (miss != '0)) begin
         score_d = bcd_dec(score_q);
      end
      if (rgt_q && !lft_q && (hrdn_q < 4'd9)) begin
         hrdn_d = hrdn_q + 4'd1;
      end else if (lft_q && !rgt_q && (hrdn_q > 4'd1)) begin
         hrdn_d = hrdn_q - 4'd1;
      end
   end

   always_ff @(posedge clk_19) begin
      if (rst) begin
         hit_clr_q <= '0;
         score_q   <= 12'h000;
         hrdn_q    <= 4'h1;
      end else begin
         hit_clr_q <= hit_clr_d;
         score_q   <= score_d;
         hrdn_q    <= hrdn_d;
      end
   end

   assign tap     = tap_q;
   assign lft     = lft_q;
   assign rgt     = rgt_q;
   assign hit_clr = hit_clr_q;
   assign score   = score_q;
   assign hrdn    = hrdn_q;

endmodule

// File: tb/tb_wam_inp.sv
// Scoreboard bench for wam_inp: stimulus pushes expected output events with their
// cycle stamps; a negedge monitor pops and compares every cycle the DUT shows activity.
module tb_wam_inp;

   logic        clk_19 = 1'b0;
   logic        rst;
   logic [7:0]  sw;
   logic        btn_l, btn_r;
   logic [7:0]  holes;
   logic        run;
   logic [7:0]  tap;
   logic        lft, rgt;
   logic [7:0]  hit_clr;
   logic [11:0] score;
   logic [3:0]  hrdn;

   wam_inp #(.DB_N(3)) dut (
      .clk_19 (clk_19),
      .rst    (rst),
      .sw     (sw),
      .btn_l  (btn_l),
      .btn_r  (btn_r),
      .holes  (holes),
      .run    (run),
      .tap    (tap),
      .lft    (lft),
      .rgt    (rgt),
      .hit_clr(hit_clr),
      .score  (score),
      .hrdn   (hrdn)
   );

   always #5 clk_19 = ~clk_19;

   int cyc = 0;
   always @(posedge clk_19) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [7:0]  tap;
      logic        lft;
      logic        rgt;
      logic [7:0]  hc;
      logic [11:0] score;
      logic [3:0]  hrdn;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   m_score = 0;
   int   m_hrdn  = 1;
   logic [11:0] prev_s;
   logic [3:0]  prev_h;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   // Queue the pulse seen at cycle p and, if anything follows from it, the judged result at p+1.
   task automatic push_pulse(input int p, input logic [7:0] t, input logic l, input logic r);
      exp_t e;
      logic [7:0] hits, miss;
      int ns, nh;
      e = '{p, t, l, r, 8'h00, to_bcd(m_score), 4'(m_hrdn)};
      q.push_back(e);
      hits = t & holes;
      miss = t & ~holes;
      ns = m_score;
      nh = m_hrdn;
      if (run && hits != 0) begin
         if (ns < 999) ns++;
      end else if (run && miss != 0) begin
         if (ns > 0) ns--;
      end
      if (r && !l && nh < 9) nh++;
      else if (l && !r && nh > 1) nh--;
      if (hits != 0 || ns != m_score || nh != m_hrdn) begin
         e = '{p + 1, 8'h00, 1'b0, 1'b0, hits, to_bcd(ns), 4'(nh)};
         q.push_back(e);
      end
      m_score = ns;
      m_hrdn  = nh;
   endtask

   task automatic tog_wait(input int i);
      logic [7:0] m;
      @(negedge clk_19);
      m = '0;
      m[i] = 1'b1;
      sw[i] = ~sw[i];
      push_pulse(cyc + 5, m, 1'b0, 1'b0);
      repeat (7) @(negedge clk_19);
   endtask

   task automatic press(input logic l, input logic r);
      @(negedge clk_19);
      btn_l = l;
      btn_r = r;
      push_pulse(cyc + 5, 8'h00, l, r);
      repeat (7) @(negedge clk_19);
      btn_l = 1'b0;
      btn_r = 1'b0;
      repeat (7) @(negedge clk_19);
   endtask

   always @(negedge clk_19) begin
      exp_t r;
      if (!rst) begin
         if (tap != 0 || lft || rgt || hit_clr != 0 || score !== prev_s || hrdn !== prev_h) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: tap=%0h lft=%0b rgt=%0b hit_clr=%0h score=%0h hrdn=%0h at cycle %0d, none expected",
                        tap, lft, rgt, hit_clr, score, hrdn, cyc);
            end else begin
               r = q.pop_front();
               chk("event_cycle", cyc, r.cyc);
               chk("tap", tap, r.tap);
               chk("lft", lft, r.lft);
               chk("rgt", rgt, r.rgt);
               chk("hit_clr", hit_clr, r.hc);
               chk("score", score, r.score);
               chk("hrdn", hrdn, r.hrdn);
            end
         end
      end
      prev_s = score;
      prev_h = hrdn;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sw = '0; btn_l = 1'b0; btn_r = 1'b0; holes = '0; run = 1'b0;
      repeat (3) @(negedge clk_19);
      chk("rst_tap", tap, 8'h00);
      chk("rst_lft_rgt", {lft, rgt}, 2'b00);
      chk("rst_hit_clr", hit_clr, 8'h00);
      chk("rst_score", score, 12'h000);
      chk("rst_hrdn", hrdn, 4'h1);
      rst = 1'b0;
      repeat (4) @(negedge clk_19);

      // Hardness: floor, climb to ceiling, simultaneous press, one step down.
      press(1'b1, 1'b0);
      chk("hrdn_floor", hrdn, 4'h1);
      for (int k = 0; k < 9; k++) press(1'b0, 1'b1);
      chk("hrdn_ceiling", hrdn, 4'h9);
      press(1'b1, 1'b1);
      chk("hrdn_both", hrdn, 4'h9);
      press(1'b1, 1'b0);
      chk("hrdn_down", hrdn, 4'h8);

      // Single hit on hole 2.
      run = 1'b1; holes = 8'h04;
      tog_wait(2);
      chk("single_hit_score", score, 12'h001);

      // Bounce: 2-cycle levels are rejected, final stable high gives one pulse.
      holes = 8'h00;
      @(negedge clk_19); sw[0] = 1'b1;
      repeat (2) @(negedge clk_19); sw[0] = 1'b0;
      repeat (2) @(negedge clk_19); sw[0] = 1'b1;
      push_pulse(cyc + 5, 8'h01, 1'b0, 1'b0);
      repeat (8) @(negedge clk_19);
      chk("bounce_miss_score", score, 12'h000);

      // Two switches together, only one lit: one point, only lit hole cleared.
      holes = 8'h01;
      @(negedge clk_19);
      sw[0] = ~sw[0]; sw[1] = ~sw[1];
      push_pulse(cyc + 5, 8'h03, 1'b0, 1'b0);
      repeat (8) @(negedge clk_19);
      chk("simul_score", score, 12'h001);

      // run low: pulses and hit_clr still appear, score frozen.
      run = 1'b0; holes = 8'h04;
      tog_wait(2);
      chk("run_low_score", score, 12'h001);

      // Rollover boundaries.
      run = 1'b1; holes = 8'hFF;
      while (m_score < 99) tog_wait(5);
      chk("score_099", score, 12'h099);
      tog_wait(5);
      chk("score_100", score, 12'h100);
      holes = 8'h00;
      tog_wait(5);
      chk("score_back_099", score, 12'h099);
      holes = 8'hFF;
      while (m_score < 999) tog_wait(5);
      chk("score_999", score, 12'h999);
      tog_wait(5);
      chk("score_sat_999", score, 12'h999);

      // Reset while sw[3] is mid-count: no pulse, reset values.
      @(negedge clk_19);
      sw[3] = 1'b1;
      repeat (3) @(negedge clk_19);
      rst = 1'b1; sw = '0;
      repeat (2) @(negedge clk_19);
      rst = 1'b0;
      m_score = 0; m_hrdn = 1;
      repeat (10) @(negedge clk_19);
      chk("midrst_score", score, 12'h000);
      chk("midrst_hrdn", hrdn, 4'h1);
      chk("midrst_tap", tap, 8'h00);

      // Miss at zero stays at zero.
      holes = 8'h00;
      tog_wait(0);
      chk("score_floor_000", score, 12'h000);

      repeat (4) @(negedge clk_19);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_events: got %0d outstanding expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
